// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the 8-bit RISC control unit.
//   - opcode constants (shared with the ALU select encoding)
//   - control FSM state enumeration
//   - Bus_1 / Bus_2 mux select encodings
//   - instruction field slice positions: opcode[7:4], src[3:2], dest[1:0]
//   - helper to build the one-hot register load vector
package risc_pkg;

  localparam int WORD_SIZE = 8;
  localparam int OP_SIZE   = 4;
  localparam int SEL1_SIZE = 3;
  localparam int SEL2_SIZE = 2;

  // Instruction field positions
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 4;
  localparam int SRC_MSB  = 3;
  localparam int SRC_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  // Opcodes; the ALU decodes the same values on its select input
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;

  // Bus_1 select: 0..3 pick R0..R3, 4 picks PC
  localparam logic [2:0] SEL1_PC = 3'd4;

  // Bus_2 select
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // One-hot load vector for R3..R0 from a 2-bit register index
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// risc_ctrl_decode: purely combinational output decoder of the control FSM.
// Inputs : state_i (current state), instruction_i (IR), zero_i (Reg_Z), rst_i
// Outputs: ALU select, Bus_1/Bus_2 selects, register/PC/IR/address/Y/Z loads,
//          memory write strobe and halted flag.
// While rst_i is high every output is forced to 0 so no partial load can
// happen when reset hits mid-instruction.
// Optional build macro: RISC_ILLEGAL_TRAP_EN (enables halted in S_HALT).
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [7:0] instruction_i,
  input  logic       zero_i,
  input  logic       rst_i,
  output logic [3:0] alu_sel_o,
  output logic [2:0] sel_bus_1_o,
  output logic [1:0] sel_bus_2_o,
  output logic [3:0] load_r_o,
  output logic       load_pc_o,
  output logic       inc_pc_o,
  output logic       load_ir_o,
  output logic       load_add_r_o,
  output logic       load_reg_y_o,
  output logic       load_reg_z_o,
  output logic       write_o,
  output logic       halted_o
);

  logic [3:0] opcode_s;
  logic [1:0] src_s;
  logic [1:0] dest_s;
  state_t     state_s;

  assign opcode_s = instruction_i[OPC_MSB:OPC_LSB];
  assign src_s    = instruction_i[SRC_MSB:SRC_LSB];
  assign dest_s   = instruction_i[DEST_MSB:DEST_LSB];
  assign state_s  = state_t'(state_i);

  // Output decode from state, IR and zero flag
  always_comb begin
    alu_sel_o    = 4'h0;
    sel_bus_1_o  = 3'd0;
    sel_bus_2_o  = 2'd0;
    load_r_o     = 4'b0000;
    load_pc_o    = 1'b0;
    inc_pc_o     = 1'b0;
    load_ir_o    = 1'b0;
    load_add_r_o = 1'b0;
    load_reg_y_o = 1'b0;
    load_reg_z_o = 1'b0;
    write_o      = 1'b0;
    halted_o     = 1'b0;
    if (rst_i) begin
      // everything stays at its inactive default
      alu_sel_o = 4'h0;
    end else begin
      case (state_s)
        S_FET1: begin
          sel_bus_1_o  = SEL1_PC;
          sel_bus_2_o  = SEL2_BUS1;
          load_add_r_o = 1'b1;
        end
        S_FET2: begin
          sel_bus_2_o = SEL2_MEM;
          load_ir_o   = 1'b1;
          inc_pc_o    = 1'b1;
        end
        S_DEC: begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_AND: begin
              // first operand goes to Reg_Y; the ALU pairs it with dest in S_EX1
              sel_bus_1_o  = {1'b0, src_s};
              sel_bus_2_o  = SEL2_BUS1;
              load_reg_y_o = 1'b1;
            end
            OP_NOT, OP_SHL, OP_SHR, OP_INC: begin
              sel_bus_1_o  = {1'b0, src_s};
              alu_sel_o    = opcode_s;
              sel_bus_2_o  = SEL2_ALU;
              load_r_o     = reg_onehot(dest_s);
              load_reg_z_o = 1'b1;
            end
            OP_RD, OP_WR, OP_BR: begin
              sel_bus_1_o  = SEL1_PC;
              sel_bus_2_o  = SEL2_BUS1;
              load_add_r_o = 1'b1;
            end
            OP_BRZ: begin
              if (zero_i) begin
                sel_bus_1_o  = SEL1_PC;
                sel_bus_2_o  = SEL2_BUS1;
                load_add_r_o = 1'b1;
              end else begin
                // not taken: step PC over the operand byte
                inc_pc_o = 1'b1;
              end
            end
            default: begin
              // NOP and opcodes C-F drive nothing here
              alu_sel_o = 4'h0;
            end
          endcase
        end
        S_EX1: begin
          sel_bus_1_o  = {1'b0, dest_s};
          alu_sel_o    = opcode_s;
          sel_bus_2_o  = SEL2_ALU;
          load_r_o     = reg_onehot(dest_s);
          load_reg_z_o = 1'b1;
        end
        S_RD1, S_WR1: begin
          sel_bus_2_o  = SEL2_MEM;
          load_add_r_o = 1'b1;
          inc_pc_o     = 1'b1;
        end
        S_RD2: begin
          sel_bus_2_o = SEL2_MEM;
          load_r_o    = reg_onehot(dest_s);
        end
        S_WR2: begin
          sel_bus_1_o = {1'b0, src_s};
          write_o     = 1'b1;
        end
        S_BR1: begin
          sel_bus_2_o  = SEL2_MEM;
          load_add_r_o = 1'b1;
        end
        S_BR2: begin
          sel_bus_2_o = SEL2_MEM;
          load_pc_o   = 1'b1;
        end
        S_HALT: begin
`ifdef RISC_ILLEGAL_TRAP_EN
          halted_o = 1'b1;
`else
          halted_o = 1'b0;
`endif
        end
        default: begin
          // S_IDLE and unused encodings drive nothing
          alu_sel_o = 4'h0;
        end
      endcase
    end
  end

endmodule

// File: rtl/risc_control_unit.sv
// risc_control_unit: control FSM of the 8-bit RISC datapath.
// Ports:
//   clk, rst (synchronous, active-high)
//   instruction - IR contents; zero - registered ALU zero flag (Reg_Z)
//   alu_sel, sel_bus_1, sel_bus_2 - ALU select and bus mux selects
//   load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z
//   write - memory write strobe; halted - FSM sits in S_HALT
// Only the state is registered; outputs are decoded combinationally by
// risc_ctrl_decode.
// Optional build macro: RISC_ILLEGAL_TRAP_EN - opcodes C-F halt the FSM
// until reset; without it they behave as NOP and halted stays 0.
module risc_control_unit
  import risc_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int op_size   = OP_SIZE,
  parameter int sel1_size = SEL1_SIZE,
  parameter int sel2_size = SEL2_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic [op_size-1:0]   alu_sel,
  output logic [sel1_size-1:0] sel_bus_1,
  output logic [sel2_size-1:0] sel_bus_2,
  output logic [3:0]           load_r,
  output logic                 load_pc,
  output logic                 inc_pc,
  output logic                 load_ir,
  output logic                 load_add_r,
  output logic                 load_reg_y,
  output logic                 load_reg_z,
  output logic                 write,
  output logic                 halted
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] opcode_s;

  assign opcode_s = instruction[OPC_MSB:OPC_LSB];

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode_s)
          OP_NOP:                         state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND:         state_d = S_EX1;
          OP_NOT, OP_SHL, OP_SHR, OP_INC: state_d = S_FET1;
          OP_RD:                          state_d = S_RD1;
          OP_WR:                          state_d = S_WR1;
          OP_BR:                          state_d = S_BR1;
          OP_BRZ: begin
            if (zero) begin
              state_d = S_BR1;
            end else begin
              state_d = S_FET1;
            end
          end
          default: begin
`ifdef RISC_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FET1;
`endif
          end
        endcase
      end
      S_EX1:  state_d = S_FET1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_FET1;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = S_FET1;
      S_BR1:  state_d = S_BR2;
      S_BR2:  state_d = S_FET1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  risc_ctrl_decode u_decode (
    .state_i       (state_q),
    .instruction_i (instruction[7:0]),
    .zero_i        (zero),
    .rst_i         (rst),
    .alu_sel_o     (alu_sel),
    .sel_bus_1_o   (sel_bus_1),
    .sel_bus_2_o   (sel_bus_2),
    .load_r_o      (load_r),
    .load_pc_o     (load_pc),
    .inc_pc_o      (inc_pc),
    .load_ir_o     (load_ir),
    .load_add_r_o  (load_add_r),
    .load_reg_y_o  (load_reg_y),
    .load_reg_z_o  (load_reg_z),
    .write_o       (write),
    .halted_o      (halted)
  );

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
Control FSM for the 8-bit RISC datapath; it sits directly upstream of the ALU and drives its 4-bit opcode select.
- Fetches the instruction from memory into IR and decodes it.
- Sequences register, bus-mux, memory and PC control for each instruction.
- Consumes the registered ALU zero flag (Reg_Z) for conditional branches.
- Instruction format: opcode[7:4], src[3:2], dest[1:0].

Parameters:
word_size, 8, instruction/data width
op_size, 4, opcode width (ALU sel width)
sel1_size, 3, Bus_1 mux select width
sel2_size, 2, Bus_2 mux select width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
instruction  input  word_size  IR contents
zero  input  1  registered ALU zero flag (Reg_Z)
alu_sel  output  op_size  ALU opcode select
sel_bus_1  output  sel1_size  0..3=R0..R3, 4=PC
sel_bus_2  output  sel2_size  0=ALU, 1=Bus_1, 2=memory
load_r  output  4  one-hot load for R3..R0
load_pc  output  1  PC <= Bus_2
inc_pc  output  1  PC <= PC+1
load_ir  output  1  IR <= Bus_2
load_add_r  output  1  address register <= Bus_2
load_reg_y  output  1  Reg_Y <= Bus_2
load_reg_z  output  1  Reg_Z <= ALU zero flag
write  output  1  memory write strobe
halted  output  1  FSM in S_HALT

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- State register: only state is registered. All outputs are decoded combinationally from state, IR and zero.
- Reset output values: while rst=1, every output is 0. At the next edge, state goes to S_IDLE. This also applies mid-instruction: no partial load may occur.
- Default output values: every output is 0 unless listed for the current state.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, SHL=9, SHR=A, INC=B.
- ALU operand mapping:
  - ALU data_1 = Reg_Y; ALU data_2 = Bus_1.
  - SUB result = dest - src.
  - Unary ops operate on Bus_1.
- State sequence:
  - S_IDLE -> S_FET1.
  - S_FET1: sel_bus_1=4, sel_bus_2=1, load_add_r -> S_FET2.
  - S_FET2: sel_bus_2=2, load_ir, inc_pc -> S_DEC.
  - S_DEC, by opcode:
    - NOP -> S_FET1.
    - ADD/SUB/AND: sel_bus_1=src, sel_bus_2=1, load_reg_y -> S_EX1.
    - NOT/SHL/SHR/INC: sel_bus_1=src, alu_sel=opcode, sel_bus_2=0, load_r[dest], load_reg_z -> S_FET1.
    - RD/WR/BR: sel_bus_1=4, sel_bus_2=1, load_add_r -> S_RD1 / S_WR1 / S_BR1 respectively.
    - BRZ with zero=1: same outputs as BR -> S_BR1.
    - BRZ with zero=0: inc_pc only (skip the operand byte) -> S_FET1.
    - opcodes C-F: see Optional Feature.
  - S_EX1: sel_bus_1=dest, alu_sel=opcode, sel_bus_2=0, load_r[dest], load_reg_z -> S_FET1.
  - S_RD1 / S_WR1: sel_bus_2=2, load_add_r, inc_pc -> S_RD2 / S_WR2.
  - S_RD2: sel_bus_2=2, load_r[dest] -> S_FET1.
  - S_WR2: sel_bus_1=src, write -> S_FET1.
  - S_BR1: sel_bus_2=2, load_add_r -> S_BR2.
  - S_BR2: sel_bus_2=2, load_pc -> S_FET1.
  - S_HALT: halted=1; remains there until rst.
- Latency (cycles per instruction, including fetch):
  - NOP=3, unary=3, binary=4, BRZ not-taken=3.
  - RD=5, WR=5, BR=5, BRZ taken=5.
- Invariants:
  - load_r is always one-hot or zero.
  - write never coincides with any load.
  - alu_sel=0 whenever sel_bus_2≠0.

Optional Feature:
Macro: RISC_ILLEGAL_TRAP_EN.
- Defined: opcodes C-F in S_DEC go to S_HALT; halted=1 until rst.
- Undefined: opcodes C-F execute as NOP (-> S_FET1); S_HALT is unreachable; halted is tied 0.

Decomposition:
- Package risc_pkg holds:
  - opcode constants, shared with the ALU;
  - state enum;
  - Bus_1/Bus_2 select encodings;
  - instruction field slice positions.
- Sub-module risc_ctrl_decode: purely combinational decoder (state, instruction, zero, rst -> outputs).
- The top level holds the state register and next-state logic.

Test Plan:
1. Reset and ADD: rst=1 for 2 cycles, then release; IR=0x16 (ADD src R1, dest R2).
   - S_FET1: sel_bus_1=4, load_add_r.
   - S_FET2: load_ir, inc_pc.
   - S_DEC: sel_bus_1=1, load_reg_y.
   - S_EX1: sel_bus_1=2, alu_sel=1, load_r=4'b0100, load_reg_z.
   - Then back to S_FET1.
2. RD: IR=0x53.
   - S_RD1: sel_bus_2=2, load_add_r, inc_pc.
   - S_RD2: load_r=4'b1000.
   - 5 cycles total.
3. BRZ not taken vs taken: IR=0x80.
   - zero=0: S_DEC asserts inc_pc only, then S_FET1.
   - zero=1: S_BR1, then S_BR2 asserts load_pc, sel_bus_2=2.
4. WR: IR=0x60.
   - S_WR2: sel_bus_1=0, write=1.
   - No load_* asserted in S_WR2.
5. Illegal opcode: IR=0xC0.
   - With RISC_ILLEGAL_TRAP_EN: halted=1, state held for 10 cycles, all other outputs 0.
   - Without the macro: back to S_FET1 after S_DEC.
6. Reset mid-instruction: rst=1 during S_EX1.
   - That cycle: all outputs 0, no load_r.
   - Next edge: S_IDLE; S_FET1 follows after release.
